boost_pi_ctrl: RTL and testbench

BOOST_PI_CTRL -- requirements
Module: boost_pi_ctrl

---
 rtl/boost_pkg.sv | 23 ++
 rtl/boost_tick_sync.sv | 28 ++
 rtl/boost_pi_ctrl.sv | 151 +++++++++++++++
 tb/tb_boost_pi_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boost_pkg.sv
// Shared constants and FSM state type for the boost converter PI controller.
package boost_pkg;

  localparam int unsigned BOOST_ADC_W = 12;
  localparam int unsigned BOOST_D_W   = 10;
  localparam int unsigned ACC_W       = 24;

  localparam logic [15:0] KP_DEFAULT    = 16'h0100;
  localparam logic [15:0] KI_DEFAULT    = 16'h0010;
  localparam logic [9:0]  D_MIN_DEFAULT = 10'd0;
  localparam logic [9:0]  D_MAX_DEFAULT = 10'd900;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    ERR  = 3'd2,
    MULP = 3'd3,
    MULI = 3'd4,
    SUM  = 3'd5,
    SAT  = 3'd6
  } state_t;

endpackage

// File: rtl/boost_tick_sync.sv
// Two-flop synchronizer for the asynchronous tick level plus a rising-edge
// detector; o_event is a one-cycle pulse per tick edge.
module boost_tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  output logic o_event
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_tick;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_event = r_sync2 & ~r_prev;

endmodule

// File: rtl/boost_pi_ctrl.sv
// Sampled PI voltage controller for a boost stage: one ADC conversion per tick,
// shared multiplier, saturating integrator. Optional BOOST_PI_ANTIWINDUP_EN.
module boost_pi_ctrl
  import boost_pkg::*;
#(
  parameter int unsigned      ADC_W = BOOST_ADC_W,
  parameter int unsigned      D_W   = BOOST_D_W,
  parameter logic [15:0]      KP    = KP_DEFAULT,
  parameter logic [15:0]      KI    = KI_DEFAULT,
  parameter logic [D_W-1:0]   D_MIN = D_MIN_DEFAULT,
  parameter logic [D_W-1:0]   D_MAX = D_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             tick,
  input  logic [ADC_W-1:0] vref,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  output logic             adc_req,
  output logic [D_W-1:0]   d_boost,
  output logic             d_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int EW = ADC_W + 1;
  localparam int PW = EW + 17;
  localparam int SW = PW + 1;
  localparam int UW = SW - 8;

  localparam logic signed [PW:0]   ACC_HI = (PW + 1)'(2 ** (ACC_W - 1) - 1);
  localparam logic signed [PW:0]   ACC_LO = ~ACC_HI;
  localparam logic signed [UW-1:0] U_MIN  = UW'(D_MIN);
  localparam logic signed [UW-1:0] U_MAX  = UW'(D_MAX);

  state_t                  r_state;
  state_t                  w_next;
  logic                    w_event;
  logic [ADC_W-1:0]        r_vref;
  logic [ADC_W-1:0]        r_adc;
  logic signed [EW-1:0]    r_e;
  logic signed [PW-1:0]    r_p;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [UW-1:0]    r_u;
  logic signed [16:0]      w_gain;
  logic signed [PW-1:0]    w_prod;
  logic signed [PW:0]      w_accSum;
  logic signed [ACC_W-1:0] w_accNext;
  logic signed [SW-1:0]    w_sum;
  logic [D_W-1:0]          w_duty;
  logic                    w_holdInt;

  boost_tick_sync u_tick_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_tick  (tick),
    .o_event (w_event)
  );

  // One multiplier serves both gains; the operand is chosen by state.
  assign w_gain = (r_state == MULI) ? $signed({1'b0, KI}) : $signed({1'b0, KP});
  assign w_prod = PW'(r_e) * PW'(w_gain);

  assign w_accSum  = (PW + 1)'(r_acc) + (PW + 1)'(w_prod);
  assign w_accNext = (w_accSum > ACC_HI) ? ACC_W'(ACC_HI) :
                     (w_accSum < ACC_LO) ? ACC_W'(ACC_LO) : ACC_W'(w_accSum);

  assign w_sum  = SW'(r_p) + SW'(r_acc);
  assign w_duty = (r_u < U_MIN) ? D_MIN : (r_u > U_MAX) ? D_MAX : D_W'(r_u);

`ifdef BOOST_PI_ANTIWINDUP_EN
  // Freeze the integrator while the previous duty is pinned and e pushes further.
  assign w_holdInt = ((d_boost == D_MAX) && !r_e[EW-1] && (r_e != '0)) ||
                     ((d_boost == D_MIN) && r_e[EW-1]);
`else
  assign w_holdInt = 1'b0;
`endif

  assign adc_req = (r_state == REQ);
  assign busy    = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (ce && w_event) w_next = REQ;
      REQ:     if (adc_valid) w_next = ERR;
      ERR:     w_next = MULP;
      MULP:    w_next = MULI;
      MULI:    w_next = SUM;
      SUM:     w_next = SAT;
      SAT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vref  <= '0;
      r_adc   <= '0;
      r_e     <= '0;
      r_p     <= '0;
      r_acc   <= '0;
      r_u     <= '0;
      d_boost <= D_MIN;
      d_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      d_valid <= 1'b0;
      if (w_event && (r_state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (!ce) begin
            r_acc   <= '0;
            d_boost <= D_MIN;
          end
        end
        REQ: begin
          if (adc_valid) begin
            r_vref <= vref;
            r_adc  <= adc_data;
          end
        end
        ERR:  r_e <= EW'(r_vref) - EW'(r_adc);
        MULP: r_p <= w_prod;
        MULI: begin
          if (!w_holdInt) begin
            r_acc <= w_accNext;
          end
        end
        SUM:  r_u <= UW'(w_sum >>> 8);
        SAT: begin
          d_boost <= w_duty;
          d_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boost_pi_ctrl.sv
// Self-checking bench for boost_pi_ctrl: directed scenarios plus randomized
// samples against an integer model of the PI law. Honors BOOST_PI_ANTIWINDUP_EN.
module tb_boost_pi_ctrl;
  import boost_pkg::*;

  localparam longint KPV    = 256;
  localparam longint KIV    = 16;
  localparam longint DMIN   = 0;
  localparam longint DMAX   = 900;
  localparam longint ACCMAX = 8388607;
  localparam longint ACCMIN = -8388608;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        tick = 1'b0;
  logic [11:0] vref = '0;
  logic [11:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        adc_req;
  logic [9:0]  d_boost;
  logic        d_valid;
  logic        busy;
  logic        overrun;

  int     checkCount = 0;
  int     errorCount = 0;
  longint mAcc = 0;
  longint mDuty = 0;
  longint mU = 0;

  always #5 clk = ~clk;

  boost_pi_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .tick      (tick),
    .vref      (vref),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .adc_req   (adc_req),
    .d_boost   (d_boost),
    .d_valid   (d_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint floorDiv256(input longint s);
    return (s >= 0) ? s / 256 : -((-s + 255) / 256);
  endfunction

  // Reference PI law on plain integers, one call per accepted sample.
  task automatic modelSample(input longint v, input longint a);
    longint e;
    longint p;
    bit     hold;
    e    = v - a;
    p    = KPV * e;
    hold = 1'b0;
`ifdef BOOST_PI_ANTIWINDUP_EN
    hold = ((mDuty == DMAX) && (e > 0)) || ((mDuty == DMIN) && (e < 0));
`endif
    if (!hold) begin
      mAcc = mAcc + KIV * e;
      if (mAcc > ACCMAX) mAcc = ACCMAX;
      if (mAcc < ACCMIN) mAcc = ACCMIN;
    end
    mU    = floorDiv256(p + mAcc);
    mDuty = (mU < DMIN) ? DMIN : (mU > DMAX) ? DMAX : mU;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    mAcc  = 0;
    mDuty = DMIN;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic waitReq(output bit seen);
    int n;
    n = 0;
    while (!adc_req && (n < 10)) begin
      @(negedge clk);
      n++;
    end
    seen = adc_req;
  endtask

  // One full sample: tick edge, ADC handshake after `delay` cycles, then
  // check the 5-cycle latency, the result and the hold afterwards.
  task automatic applyStimulus(input logic [11:0] v, input logic [11:0] a, input int delay);
    bit seen;
    int early;
    vref     = v;
    adc_data = 12'($urandom);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    waitReq(seen);
    tick = 1'b0;
    checkOutput("adc_req raised", longint'(seen), 1);
    if (!seen) return;
    repeat (delay) @(negedge clk);
    adc_data  = a;
    adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
    adc_data  = 12'($urandom);
    vref      = 12'($urandom);
    modelSample(longint'(v), longint'(a));
    early = 0;
    repeat (4) begin
      @(negedge clk);
      early += int'(d_valid);
    end
    checkOutput("d_valid early", early, 0);
    @(negedge clk);
    checkOutput("d_valid pulse", d_valid, 1);
    checkOutput("d_boost", d_boost, mDuty);
    checkOutput("acc", dut.r_acc, mAcc);
    @(negedge clk);
    checkOutput("d_valid one cycle", d_valid, 0);
    checkOutput("d_boost hold", d_boost, mDuty);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    int pulses;

    repeat (3) @(negedge clk);
    checkOutput("reset adc_req", adc_req, 0);
    checkOutput("reset d_boost", d_boost, DMIN);
    checkOutput("reset d_valid", d_valid, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset overrun", overrun, 0);
    rst_n = 1'b1;
    ce    = 1'b1;
    mDuty = DMIN;
    @(negedge clk);

    adc_valid = 1'b1;
    adc_data  = 12'hABC;
    @(negedge clk);
    adc_valid = 1'b0;
    @(negedge clk);
    checkOutput("stray adc_valid busy", busy, 0);

    $display("[TB] step from reset");
    applyStimulus(12'd2048, 12'd1948, 1);
    checkOutput("step d_boost", d_boost, 106);

    $display("[TB] integration");
    applyStimulus(12'd2048, 12'd1948, 0);
    checkOutput("integ d_boost", d_boost, 112);
    checkOutput("integ acc", dut.r_acc, 3200);

    $display("[TB] upper saturation, 10 ticks");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(12'd4095, 12'd0, int'($urandom_range(0, 3)));
    end
    checkOutput("upper d_boost", d_boost, 900);
`ifdef BOOST_PI_ANTIWINDUP_EN
    checkOutput("antiwindup acc", dut.r_acc, 68720);
`else
    checkOutput("windup acc", dut.r_acc, 658400);
`endif

    $display("[TB] lower saturation");
    doReset();
    applyStimulus(12'd2048, 12'd2148, 2);
    checkOutput("lower d_boost", d_boost, 0);
`ifdef BOOST_PI_ANTIWINDUP_EN
    checkOutput("lower u", dut.r_u, -100);
`else
    checkOutput("lower u", dut.r_u, -107);
`endif

    $display("[TB] ce low ignores ticks");
    doReset();
    ce = 1'b0;
    tick = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      pulses += int'(adc_req);
    end
    tick = 1'b0;
    checkOutput("ce0 adc_req", pulses, 0);
    checkOutput("ce0 overrun", overrun, 0);

    $display("[TB] overrun");
    repeat (3) @(negedge clk);
    ce   = 1'b1;
    vref = 12'd2048;
    tick = 1'b1;
    @(negedge clk);
    waitReq(seen);
    tick = 1'b0;
    checkOutput("ovr adc_req", longint'(seen), 1);
    repeat (3) @(negedge clk);
    tick = 1'b1;
    repeat (4) @(negedge clk);
    tick = 1'b0;
    checkOutput("ovr flag", overrun, 1);
    checkOutput("ovr busy", busy, 1);
    adc_data  = 12'd1948;
    adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
    modelSample(2048, 1948);
    pulses = 0;
    repeat (14) begin
      @(negedge clk);
      pulses += int'(d_valid);
    end
    checkOutput("ovr d_valid count", pulses, 1);
    checkOutput("ovr d_boost", d_boost, mDuty);
    ce = 1'b0;
    repeat (2) @(negedge clk);
    mAcc  = 0;
    mDuty = DMIN;
    checkOutput("ce0 d_boost", d_boost, 0);
    checkOutput("ce0 acc", dut.r_acc, 0);
    checkOutput("ovr sticky", overrun, 1);

    $display("[TB] reset during MULI");
    ce   = 1'b1;
    vref = 12'd3000;
    tick = 1'b1;
    @(negedge clk);
    waitReq(seen);
    tick = 1'b0;
    checkOutput("mid adc_req", longint'(seen), 1);
    adc_data  = 12'd100;
    adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("mid state", dut.r_state, MULI);
    rst_n = 1'b0;
    #1;
    checkOutput("mid adc_req", adc_req, 0);
    checkOutput("mid d_boost", d_boost, DMIN);
    checkOutput("mid busy", busy, 0);
    checkOutput("mid overrun", overrun, 0);
    checkOutput("mid acc", dut.r_acc, 0);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      pulses += int'(d_valid);
    end
    checkOutput("mid no d_valid", pulses, 0);
    rst_n = 1'b1;
    mAcc  = 0;
    mDuty = DMIN;
    @(negedge clk);

    $display("[TB] randomized samples");
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        ce = 1'b0;
        repeat (3) @(negedge clk);
        mAcc  = 0;
        mDuty = DMIN;
        checkOutput("rand ce0 d_boost", d_boost, DMIN);
        ce = 1'b1;
      end
      applyStimulus(12'($urandom), 12'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, errorCount);
    $finish;
  end

endmodule
